// File: rtl/uart_bus_bridge_if.sv
// Byte-side UART handshake and 32-bit memory bus seen by the UART bus bridge.
// The master modport is the bridge; the slave modport is the UART core plus memory side.
interface uart_bus_bridge_if;
  logic        rx_received;
  logic [7:0]  rx_byte;
  logic        rx_error;
  logic        tx_busy;
  logic        tx_transmit;
  logic [7:0]  tx_byte;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  modport master (
    input  rx_received, rx_byte, rx_error, tx_busy, mem_ready, mem_rdata,
    output tx_transmit, tx_byte, mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output rx_received, rx_byte, rx_error, tx_busy, mem_ready, mem_rdata,
    input  tx_transmit, tx_byte, mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// Host command engine: parses 'R'/'W' frames from UART bytes, performs one 32-bit
// bus access per frame and streams the response back through the UART transmitter.
module uart_bus_bridge #(
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  OP_READ        = 8'h52,
  parameter logic [7:0]  OP_WRITE       = 8'h57
) (
  input  logic               clk,
  input  logic               rst,
  uart_bus_bridge_if.master  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS, S_SEND, S_WAIT_HI, S_WAIT_LO
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_cnt;
  logic [TW-1:0] r_tmo;
  logic          r_is_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_resp;

  logic          w_op_ok;
  logic          w_tmo_hit;
  logic          w_field_done;

  assign w_op_ok      = (bus.rx_byte == OP_READ) || (bus.rx_byte == OP_WRITE);
  assign w_tmo_hit    = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_field_done = bus.rx_received && (r_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_received) w_next = w_op_ok ? S_ADDR : S_SEND;
      end
      S_ADDR: begin
        // a framing error discards the frame even if a byte strobe arrives with it
        if (bus.rx_error)  w_next = S_IDLE;
        else if (w_field_done) w_next = r_is_write ? S_DATA : S_BUS;
        else if (!bus.rx_received && w_tmo_hit) w_next = S_IDLE;
      end
      S_DATA: begin
        if (bus.rx_error)  w_next = S_IDLE;
        else if (w_field_done) w_next = S_BUS;
        else if (!bus.rx_received && w_tmo_hit) w_next = S_IDLE;
      end
      S_BUS: begin
        if (bus.mem_ready) w_next = S_SEND;
      end
      S_SEND: begin
        if (!bus.tx_busy) w_next = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.tx_busy) w_next = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy) w_next = (r_cnt != 2'd0) ? S_SEND : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_cnt counts field bytes while receiving and remaining response bytes while sending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 2'd0;
      r_tmo      <= '0;
      r_is_write <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_resp     <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          r_cnt <= 2'd0;
          if (bus.rx_received) begin
            if (w_op_ok) r_is_write <= (bus.rx_byte == OP_WRITE);
            else         r_resp     <= {8'h3F, 24'h0};
          end
        end
        S_ADDR, S_DATA: begin
          if (bus.rx_error) begin
            r_cnt <= 2'd0;
            r_tmo <= '0;
          end else if (bus.rx_received) begin
            r_tmo <= '0;
            r_cnt <= r_cnt + 2'd1;
            if (r_state == S_ADDR) r_addr  <= {r_addr[23:0], bus.rx_byte};
            else                   r_wdata <= {r_wdata[23:0], bus.rx_byte};
          end else if (w_tmo_hit) begin
            r_tmo <= '0;
            r_cnt <= 2'd0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_BUS: begin
          if (bus.mem_ready) begin
            if (r_is_write) begin
              r_resp <= {8'h4B, 24'h0};
              r_cnt  <= 2'd0;
            end else begin
              r_resp <= bus.mem_rdata;
              r_cnt  <= 2'd3;
            end
          end
        end
        S_WAIT_LO: begin
          if (!bus.tx_busy && (r_cnt != 2'd0)) begin
            r_cnt  <= r_cnt - 2'd1;
            r_resp <= {r_resp[23:0], 8'h00};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_req     = (r_state == S_BUS);
    bus.mem_we      = (r_state == S_BUS) && r_is_write;
    bus.mem_addr    = r_addr;
    bus.mem_wdata   = r_wdata;
    bus.tx_transmit = (r_state == S_SEND) && !bus.tx_busy;
    bus.tx_byte     = r_resp[31:24];
    bus.busy        = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge with simple UART-transmitter and memory responders.
module tb_uart_bus_bridge;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_bus_bridge_if bus ();

  uart_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // responder settings written only by the main sequence
  int          mem_lat    = 0;
  logic [31:0] rd_val     = 32'h0;
  int          busy_delay = 0;

  // observations written only by the responders
  int          n_req  = 0;
  int          n_done = 0;
  logic        cap_we = 1'b0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic [7:0]  tx_q[$];
  int          n_tx_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte     = b;
    bus.rx_received = 1'b1;
    @(negedge clk);
    bus.rx_received = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    if (op == 8'h57) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({tag, " idle timeout"}, 32'(bus.busy), 32'h0);
  endtask

  task automatic wait_tx(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (tx_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({tag, " tx timeout"}, 32'(tx_q.size()), 32'(target));
  endtask

  // memory responder: ready after mem_lat request cycles (0 = first request cycle)
  initial begin
    int   cyc;
    logic prev_req;
    cyc = 0;
    prev_req = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !prev_req) n_req++;
      prev_req = bus.mem_req;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        cyc = 0;
      end else if (bus.mem_req) begin
        if (cyc >= mem_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rd_val;
          cap_we    = bus.mem_we;
          cap_addr  = bus.mem_addr;
          cap_wdata = bus.mem_wdata;
          n_done++;
          cyc = 0;
        end else cyc++;
      end else cyc = 0;
    end
  end

  // UART transmitter: busy rises busy_delay+1 cycles after a request, stays 4 cycles
  initial begin
    int   st;
    int   bc;
    logic prev_tx;
    st = 0;
    bc = 0;
    prev_tx = 1'b0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_transmit && (bus.tx_busy || prev_tx || st != 0)) n_tx_err++;
      prev_tx = bus.tx_transmit;
      if (st == 0) begin
        if (bus.tx_transmit) begin
          tx_q.push_back(bus.tx_byte);
          st = 1;
          bc = 0;
        end
      end else if (st == 1) begin
        if (bc >= busy_delay) begin
          bus.tx_busy = 1'b1;
          st = 2;
          bc = 0;
        end else bc++;
      end else begin
        if (bc >= 3) begin
          bus.tx_busy = 1'b0;
          st = 0;
        end else bc++;
      end
    end
  end

  initial begin
    int r0, t0;
    bus.rx_received = 1'b0;
    bus.rx_byte     = 8'h00;
    bus.rx_error    = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy",  32'(bus.busy), 32'h0);
    check("rst req",   32'(bus.mem_req), 32'h0);
    check("rst we",    32'(bus.mem_we), 32'h0);
    check("rst txreq", 32'(bus.tx_transmit), 32'h0);
    check("rst txb",   32'(bus.tx_byte), 32'h0);
    check("rst addr",  bus.mem_addr, 32'h0);
    check("rst wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;

    // write frame, two wait cycles on the bus
    mem_lat = 2;
    r0 = n_req; t0 = tx_q.size();
    send_frame(8'h57, 32'h0000_1000, 32'hDEAD_BEEF);
    check("w req latency", 32'(bus.mem_req), 32'h1);
    check("w we", 32'(bus.mem_we), 32'h1);
    wait_idle("w", 200);
    check("w nreq", 32'(n_req - r0), 32'h1);
    check("w cap we", 32'(cap_we), 32'h1);
    check("w cap addr", cap_addr, 32'h0000_1000);
    check("w cap wdata", cap_wdata, 32'hDEAD_BEEF);
    check("w ntx", 32'(tx_q.size() - t0), 32'h1);
    if (tx_q.size() > t0) check("w tx K", 32'(tx_q[t0]), 32'h4B);
    @(negedge clk);
    check("w busy after", 32'(bus.busy), 32'h0);

    // read frame, ready in the first request cycle
    mem_lat = 0; rd_val = 32'h1234_5678;
    r0 = n_req; t0 = tx_q.size();
    send_frame(8'h52, 32'h0000_2004, 32'h0);
    wait_idle("r", 300);
    check("r nreq", 32'(n_req - r0), 32'h1);
    check("r cap we", 32'(cap_we), 32'h0);
    check("r cap addr", cap_addr, 32'h0000_2004);
    check("r ntx", 32'(tx_q.size() - t0), 32'h4);
    if (tx_q.size() >= t0 + 4)
      check("r tx bytes", {tx_q[t0], tx_q[t0+1], tx_q[t0+2], tx_q[t0+3]}, 32'h1234_5678);

    // unknown opcode, then a normal read
    r0 = n_req; t0 = tx_q.size();
    send_byte(8'h41);
    wait_idle("u", 100);
    check("u nreq", 32'(n_req - r0), 32'h0);
    check("u ntx", 32'(tx_q.size() - t0), 32'h1);
    if (tx_q.size() > t0) check("u tx ?", 32'(tx_q[t0]), 32'h3F);
    rd_val = 32'hCAFE_F00D; r0 = n_req; t0 = tx_q.size();
    send_frame(8'h52, 32'h0000_0004, 32'h0);
    wait_idle("u2", 300);
    check("u2 cap addr", cap_addr, 32'h0000_0004);
    if (tx_q.size() >= t0 + 4)
      check("u2 tx bytes", {tx_q[t0], tx_q[t0+1], tx_q[t0+2], tx_q[t0+3]}, 32'hCAFE_F00D);
    else check("u2 ntx", 32'(tx_q.size() - t0), 32'h4);

    // inter-byte timeout
    r0 = n_req; t0 = tx_q.size();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    repeat (TMO - 1) @(negedge clk);
    check("tmo busy before", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("tmo busy after", 32'(bus.busy), 32'h0);
    repeat (5) @(negedge clk);
    check("tmo nreq", 32'(n_req - r0), 32'h0);
    check("tmo ntx", 32'(tx_q.size() - t0), 32'h0);
    rd_val = 32'h0BAD_F00D;
    send_frame(8'h52, 32'h0000_0040, 32'h0);
    wait_idle("tmo2", 300);
    check("tmo2 nreq", 32'(n_req - r0), 32'h1);
    check("tmo2 addr", cap_addr, 32'h0000_0040);
    check("tmo2 ntx", 32'(tx_q.size() - t0), 32'h4);

    // framing error coincident with the third address byte
    r0 = n_req; t0 = tx_q.size();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    bus.rx_byte = 8'h11; bus.rx_received = 1'b1; bus.rx_error = 1'b1;
    @(negedge clk);
    bus.rx_received = 1'b0; bus.rx_error = 1'b0;
    check("err busy", 32'(bus.busy), 32'h0);
    repeat (TMO + 5) @(negedge clk);
    check("err nreq", 32'(n_req - r0), 32'h0);
    check("err ntx", 32'(tx_q.size() - t0), 32'h0);

    // bytes arriving during a read response are dropped
    rd_val = 32'hA1B2_C3D4; r0 = n_req; t0 = tx_q.size();
    send_frame(8'h52, 32'h0000_0100, 32'h0);
    wait_tx("drop", t0 + 1, 100);
    send_byte(8'h57); send_byte(8'h41);
    wait_idle("drop", 300);
    repeat (5) @(negedge clk);
    check("drop busy", 32'(bus.busy), 32'h0);
    check("drop nreq", 32'(n_req - r0), 32'h1);
    check("drop ntx", 32'(tx_q.size() - t0), 32'h4);
    if (tx_q.size() >= t0 + 4)
      check("drop tx bytes", {tx_q[t0], tx_q[t0+1], tx_q[t0+2], tx_q[t0+3]}, 32'hA1B2_C3D4);

    // reset while the bus request is pending
    mem_lat = 100;
    send_frame(8'h57, 32'h0000_0200, 32'h5555_AAAA);
    check("rb req", 32'(bus.mem_req), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rb req0", 32'(bus.mem_req), 32'h0);
    check("rb we0", 32'(bus.mem_we), 32'h0);
    check("rb busy0", 32'(bus.busy), 32'h0);
    check("rb tx0", 32'(bus.tx_transmit), 32'h0);
    check("rb addr0", bus.mem_addr, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset while waiting for the transmitter to go busy
    mem_lat = 0; busy_delay = 30; t0 = tx_q.size();
    send_frame(8'h57, 32'h0000_0300, 32'h0000_0001);
    wait_tx("rw", t0 + 1, 100);
    repeat (2) @(negedge clk);
    check("rw busy pre", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rw busy0", 32'(bus.busy), 32'h0);
    check("rw tx0", 32'(bus.tx_transmit), 32'h0);
    check("rw txb0", 32'(bus.tx_byte), 32'h0);
    check("rw req0", 32'(bus.mem_req), 32'h0);
    check("rw wdata0", bus.mem_wdata, 32'h0);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    busy_delay = 0;
    check("rw ntx", 32'(tx_q.size() - t0), 32'h1);
    check("rw idle", 32'(bus.busy), 32'h0);

    check("tx protocol errors", 32'(n_tx_err), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end
endmodule
